// File: rtl/rv32i_pkg.sv
// Shared opcode encodings, sequencer state and opcode-class types for the rv32i control path.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        HALT
    } seq_state_t;

    typedef enum logic [2:0] {
        ALU,
        LOAD,
        STORE,
        BRANCH,
        FENCE
    } op_class_t;

    typedef struct packed {
        logic      legal;
        logic      system;
        op_class_t cls;
    } op_decode_t;

    // SYSTEM is legal but halts; anything unlisted is illegal.
    function automatic op_decode_t decode_op(input logic [6:0] opc);
        op_decode_t d;
        d.legal  = 1'b1;
        d.system = 1'b0;
        d.cls    = ALU;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OP_IMM, OPC_OP: d.cls    = ALU;
            OPC_LOAD:           d.cls    = LOAD;
            OPC_STORE:          d.cls    = STORE;
            OPC_BRANCH:         d.cls    = BRANCH;
            OPC_FENCE:          d.cls    = FENCE;
            OPC_SYSTEM:         d.system = 1'b1;
            default:            d.legal  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module seq_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the rv32i core: per-stage enables, data-memory
// handshake with timeout, halt on SYSTEM/illegal opcodes, cycle and retire counts.
module multicycle_sequencer
    import rv32i_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ack,
    output logic             ir_en,
    output logic             pc_en,
    output logic             reg_write,
    output logic             mem_req,
    output logic             mem_write,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    // state   | meaning
    // IDLE    | stopped at an instruction boundary, waiting for run
    // FETCH   | load IR from instruction memory
    // DECODE  | classify opcode, latch class, halt on SYSTEM/illegal
    // EXECUTE | ALU step; BRANCH/FENCE retire here
    // MEM     | data-memory request held until ack or timeout
    // WB      | register-file write, retire
    // HALT    | absorbing until reset

    localparam logic [7:0] WAIT_LOAD = 8'(MAX_WAIT - 1);

    seq_state_t state, state_nxt;
    op_class_t  op_class;
    op_decode_t dec;
    logic [7:0] wait_cnt;
    logic       retire;
    logic       set_illegal;
    logic       set_bus_err;

    assign dec = decode_op(opcode);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_class <= ALU;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DECODE) begin
                op_class <= dec.cls;
            end
            // Down-counter reloaded on every MEM entry; zero marks the last permitted cycle.
            if (state == EXECUTE) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == MEM && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state)
            IDLE:    if (run) state_nxt = FETCH;
            FETCH:   state_nxt = DECODE;
            DECODE: begin
                if (dec.system) begin
                    state_nxt = HALT;
                end else if (!dec.legal) begin
                    state_nxt   = HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                case (op_class)
                    LOAD, STORE:   state_nxt = MEM;
                    BRANCH, FENCE: retire    = 1'b1;
                    default:       state_nxt = WB;
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    if (op_class == STORE) retire = 1'b1;
                    else                   state_nxt = WB;
                end else if (wait_cnt == '0) begin
                    state_nxt   = HALT;
                    set_bus_err = 1'b1;
                end
            end
            WB:      retire = 1'b1;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
        // run is sampled at the retire boundary, so a dropped run finishes the current instruction.
        if (retire) begin
            state_nxt = run ? FETCH : IDLE;
        end
    end

    always_comb begin
        ir_en     = (state == FETCH);
        pc_en     = retire;
        reg_write = (state == WB);
        mem_req   = (state == MEM);
        mem_write = (state == MEM) && (op_class == STORE);
        busy      = (state != IDLE) && (state != HALT);
        halted    = (state == HALT);
    end

    seq_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .clr   (1'b0),
        .count (cycle_count)
    );

    seq_counter #(.W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (retire),
        .clr   (1'b0),
        .count (instret_count)
    );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer; a second 4-bit-counter instance checks counter wrap.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [6:0]  opcode;
    logic        mem_ack;

    logic        ir_en, pc_en, reg_write, mem_req, mem_write;
    logic        busy, halted, illegal, bus_err;
    logic [31:0] cycle_count, instret_count;

    logic        w4_ir_en, w4_pc_en, w4_reg_write, w4_mem_req, w4_mem_write;
    logic        w4_busy, w4_halted, w4_illegal, w4_bus_err;
    logic [3:0]  w4_cycle_count, w4_instret_count;

    int n_vec = 0;
    int n_err = 0;
    int cnt;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .opcode        (opcode),
        .mem_ack       (mem_ack),
        .ir_en         (ir_en),
        .pc_en         (pc_en),
        .reg_write     (reg_write),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .busy          (busy),
        .halted        (halted),
        .illegal       (illegal),
        .bus_err       (bus_err),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    multicycle_sequencer #(.CNT_W(4)) dut_w4 (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .opcode        (opcode),
        .mem_ack       (mem_ack),
        .ir_en         (w4_ir_en),
        .pc_en         (w4_pc_en),
        .reg_write     (w4_reg_write),
        .mem_req       (w4_mem_req),
        .mem_write     (w4_mem_write),
        .busy          (w4_busy),
        .halted        (w4_halted),
        .illegal       (w4_illegal),
        .bus_err       (w4_bus_err),
        .cycle_count   (w4_cycle_count),
        .instret_count (w4_instret_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        run     = 1'b0;
        opcode  = 7'd0;
        mem_ack = 1'b0;

        // Reset held low
        step();
        step();
        chk("rst_outs", 32'({ir_en, pc_en, reg_write, mem_req, mem_write,
                             busy, halted, illegal, bus_err}), 32'd0);
        chk("rst_cycle", cycle_count, 32'd0);
        chk("rst_instret", instret_count, 32'd0);
        reset = 1'b1;
        step();
        chk("idle_no_run", 32'(busy), 32'd0);

        // 20 back-to-back ALU instructions; 4-bit counters wrap
        opcode = OP_OP;
        run    = 1'b1;
        step();
        chk("wrap_first_fetch", 32'(ir_en), 32'd1);
        repeat (79) step();
        chk("wrap_last_wb", 32'(reg_write), 32'd1);
        run = 1'b0;
        step();
        chk("wrap_idle", 32'(busy), 32'd0);
        chk("wrap_instret32", instret_count, 32'd20);
        chk("wrap_instret4", 32'(w4_instret_count), 32'd4);
        chk("wrap_cycle32", cycle_count, 32'd80);
        chk("wrap_cycle4", 32'(w4_cycle_count), 32'd0);

        // Single OP; opcode change after DECODE must not matter
        do_reset();
        opcode = OP_OP;
        run    = 1'b1;
        step();
        chk("op_fetch_ir_en", 32'(ir_en), 32'd1);
        run = 1'b0;
        step();
        chk("op_decode_ir_en", 32'(ir_en), 32'd0);
        step();
        chk("op_exec_rw", 32'(reg_write), 32'd0);
        opcode = OP_LOAD;
        step();
        chk("op_wb_rw", 32'(reg_write), 32'd1);
        chk("op_wb_pc_en", 32'(pc_en), 32'd1);
        chk("op_wb_no_req", 32'(mem_req), 32'd0);
        step();
        chk("op_idle", 32'(busy), 32'd0);
        chk("op_instret", instret_count, 32'd1);
        chk("op_cycle", cycle_count, 32'd4);

        // LOAD with ack delayed 3 cycles
        do_reset();
        opcode = OP_LOAD;
        run    = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_req) cnt++;
            if (i == 0) chk("ld_mem_write", 32'(mem_write), 32'd0);
            if (i == 3) mem_ack = 1'b1;
        end
        step();
        mem_ack = 1'b0;
        chk("ld_req_cycles", cnt, 32'd4);
        chk("ld_wb_rw", 32'(reg_write), 32'd1);
        chk("ld_wb_req_low", 32'(mem_req), 32'd0);
        step();
        chk("ld_cycle", cycle_count, 32'd8);
        chk("ld_instret", instret_count, 32'd1);

        // STORE acked in the final permitted MEM cycle completes
        do_reset();
        opcode = OP_STORE;
        run    = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 14) begin
                mem_ack = 1'b1;
                #1;
                chk("st_last_pc_en", 32'(pc_en), 32'd1);
                chk("st_last_mem_write", 32'(mem_write), 32'd1);
            end
        end
        step();
        mem_ack = 1'b0;
        chk("st_last_busy", 32'(busy), 32'd0);
        chk("st_last_bus_err", 32'(bus_err), 32'd0);
        chk("st_last_instret", instret_count, 32'd1);
        chk("st_last_cycle", cycle_count, 32'd18);

        // STORE never acked -> bus error after 15 MEM cycles
        do_reset();
        opcode = OP_STORE;
        run    = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        cnt = 0;
        repeat (15) begin
            step();
            if (mem_req) cnt++;
        end
        chk("to_req_cycles", cnt, 32'd15);
        chk("to_not_yet_halted", 32'(halted), 32'd0);
        step();
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_req_dropped", 32'(mem_req), 32'd0);
        chk("to_illegal", 32'(illegal), 32'd0);
        chk("to_instret", instret_count, 32'd0);
        chk("to_cycle", cycle_count, 32'd18);
        run = 1'b1;
        repeat (3) step();
        chk("to_stays_halted", 32'(halted), 32'd1);
        chk("to_no_fetch", 32'(ir_en), 32'd0);
        chk("to_cycle_frozen", cycle_count, 32'd18);

        // Illegal opcode
        do_reset();
        opcode = OP_BAD;
        run    = 1'b1;
        step();
        step();
        step();
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_bus_err", 32'(bus_err), 32'd0);
        chk("ill_instret", instret_count, 32'd0);
        chk("ill_cycle", cycle_count, 32'd2);
        run = 1'b0;
        step();
        run = 1'b1;
        step();
        step();
        chk("ill_run_toggle_halted", 32'(halted), 32'd1);
        chk("ill_run_toggle_busy", 32'(busy), 32'd0);
        chk("ill_run_toggle_ir", 32'(ir_en), 32'd0);

        // SYSTEM halts without illegal
        do_reset();
        opcode = OP_SYSTEM;
        run    = 1'b1;
        step();
        step();
        step();
        chk("sys_halted", 32'(halted), 32'd1);
        chk("sys_illegal", 32'(illegal), 32'd0);
        chk("sys_instret", instret_count, 32'd0);

        // Back-to-back BRANCH, run dropped in second EXECUTE
        do_reset();
        opcode = OP_BRANCH;
        run    = 1'b1;
        step();
        chk("br_c1_ir_en", 32'(ir_en), 32'd1);
        step();
        step();
        chk("br_c3_pc_en", 32'(pc_en), 32'd1);
        step();
        chk("br_c4_ir_en", 32'(ir_en), 32'd1);
        step();
        step();
        chk("br_c6_pc_en", 32'(pc_en), 32'd1);
        run = 1'b0;
        step();
        chk("br_c7_idle", 32'(busy), 32'd0);
        cnt = 0;
        repeat (3) begin
            step();
            if (ir_en) cnt++;
        end
        chk("br_no_more_fetch", cnt, 32'd0);
        chk("br_instret", instret_count, 32'd2);
        chk("br_cycle", cycle_count, 32'd6);

        // Async reset mid-MEM
        do_reset();
        opcode = OP_LOAD;
        run    = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        step();
        chk("ar_in_mem", 32'(mem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("ar_req_dropped", 32'(mem_req), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_cycle", cycle_count, 32'd0);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
